// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package inst_fetch_pkg;

    // Pipeline stall vector; bit 0 is the IF hold request.
    localparam int STALL_W     = 6;
    localparam logic STOP      = 1'b1;
    localparam logic NO_STOP   = 1'b0;

    // Redirect bus {br_e, br_addr} and IF->ID bus {ce, pc}.
    localparam int BR_WD       = 33;
    localparam int IF_TO_ID_WD = 33;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } if_state_e;

endpackage

// File: rtl/inst_fetch_pc_next_sel.sv
// Next-PC priority mux: live redirect, then pending redirect, then sequential.
module pc_next_sel
    import inst_fetch_pkg::*;
(
    input  logic        br_e,
    input  logic [31:0] br_addr,
    input  logic        pend_v,
    input  logic [31:0] pend_addr,
    input  logic [31:0] pc,
    output logic [31:0] pc_next
);

    // Select the next fetch address; pc+4 wraps naturally at 32 bits.
    always_comb begin
        pc_next = pc + 32'd4;
        if (br_e) begin
            pc_next = br_addr;
        end else if (pend_v) begin
            pc_next = pend_addr;
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC register, redirect capture while stalled,
// and the instruction SRAM read request.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'hBFBF_FFFC
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [STALL_W-1:0]     stall,
    input  logic [BR_WD-1:0]       br_bus,
    output logic [IF_TO_ID_WD-1:0] if_to_id_bus,
    output logic                   inst_sram_en,
    output logic [3:0]             inst_sram_wen,
    output logic [31:0]            inst_sram_addr,
    output logic [31:0]            inst_sram_wdata
);

    if_state_e   state_p0, state_nxt;
    logic [31:0] pc_p0, pc_nxt;
    logic        ce_p0, ce_nxt;
    logic        pend_v_p0, pend_v_nxt;
    logic [31:0] pend_addr_p0, pend_addr_nxt;

    logic        br_e;
    logic [31:0] br_addr;
    logic        if_hold;
    logic [31:0] pc_sel;
    logic        unused_stall;

    assign br_e         = br_bus[32];
    assign br_addr      = br_bus[31:0];
    assign if_hold      = (stall[0] == STOP);
    assign unused_stall = ^stall[STALL_W-1:1];

    pc_next_sel u_pc_next_sel (
        .br_e      (br_e),
        .br_addr   (br_addr),
        .pend_v    (pend_v_p0),
        .pend_addr (pend_addr_p0),
        .pc        (pc_p0),
        .pc_next   (pc_sel)
    );

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_p0 <= IDLE;
        end else begin
            state_p0 <= state_nxt;
        end
    end

    // Next-state logic: leave IDLE on the first edge, then track the IF hold.
    always_comb begin
        state_nxt = state_p0;
        case (state_p0)
            IDLE:        state_nxt = FETCH;
            FETCH, HOLD: state_nxt = if_hold ? HOLD : FETCH;
            default:     state_nxt = IDLE;
        endcase
    end

    // Datapath next values: advance PC when free, capture redirects when held.
    always_comb begin
        pc_nxt        = pc_p0;
        ce_nxt        = ce_p0;
        pend_v_nxt    = pend_v_p0;
        pend_addr_nxt = pend_addr_p0;
        case (state_p0)
            IDLE: begin
                pc_nxt     = RESET_PC + 32'd4;
                ce_nxt     = 1'b1;
                pend_v_nxt = 1'b0;
            end
            FETCH, HOLD: begin
                if (if_hold) begin
                    // A later redirect overwrites an earlier one during the hold.
                    if (br_e) begin
                        pend_v_nxt    = 1'b1;
                        pend_addr_nxt = br_addr;
                    end
                end else begin
                    pc_nxt     = pc_sel;
                    ce_nxt     = 1'b1;
                    pend_v_nxt = 1'b0;
                end
            end
            default: begin
                pc_nxt     = RESET_PC;
                ce_nxt     = 1'b0;
                pend_v_nxt = 1'b0;
            end
        endcase
    end

    // PC, enable and pending-redirect registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_p0        <= RESET_PC;
            ce_p0        <= 1'b0;
            pend_v_p0    <= 1'b0;
            pend_addr_p0 <= 32'h0;
        end else begin
            pc_p0        <= pc_nxt;
            ce_p0        <= ce_nxt;
            pend_v_p0    <= pend_v_nxt;
            pend_addr_p0 <= pend_addr_nxt;
        end
    end

    assign if_to_id_bus    = {ce_p0, pc_p0};
    assign inst_sram_en    = ce_p0;
    assign inst_sram_wen   = 4'b0000;
    assign inst_sram_addr  = pc_p0;
    assign inst_sram_wdata = 32'h0;

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;
    import inst_fetch_pkg::*;

    logic                   clk;
    logic                   rst;
    logic [STALL_W-1:0]     stall;
    logic [BR_WD-1:0]       br_bus;
    logic [IF_TO_ID_WD-1:0] if_to_id_bus;
    logic                   inst_sram_en;
    logic [3:0]             inst_sram_wen;
    logic [31:0]            inst_sram_addr;
    logic [31:0]            inst_sram_wdata;

    int checks   = 0;
    int failures = 0;

    inst_fetch dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .br_bus          (br_bus),
        .if_to_id_bus    (if_to_id_bus),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_wen   (inst_sram_wen),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Checks enable, address and the IF->ID bus together.
    task automatic check_fetch(input string tag, input logic ce, input logic [31:0] addr);
        check({tag, "_en"},   {32'h0, inst_sram_en}, {32'h0, ce});
        check({tag, "_addr"}, {1'b0, inst_sram_addr}, {1'b0, addr});
        check({tag, "_bus"},  if_to_id_bus, {ce, addr});
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_br(input logic e, input logic [31:0] a);
        br_bus = {e, a};
    endtask

    initial begin
        rst    = 1'b0;
        stall  = '0;
        br_bus = '0;
        tick();
        tick();

        // Reset state and constant outputs
        check_fetch("reset", 1'b0, 32'hBFBF_FFFC);
        check("wen",   {29'h0, inst_sram_wen}, 33'h0);
        check("wdata", {1'b0, inst_sram_wdata}, 33'h0);

        // Release: ce stays low this cycle, then sequential fetch
        rst = 1'b1;
        #2;
        check_fetch("post_release", 1'b0, 32'hBFBF_FFFC);
        tick(); check_fetch("seq0", 1'b1, 32'hBFC0_0000);
        tick(); check_fetch("seq1", 1'b1, 32'hBFC0_0004);
        tick(); check_fetch("seq2", 1'b1, 32'hBFC0_0008);

        // Live redirect, one-cycle latency
        set_br(1'b1, 32'hBFC0_0100);
        tick(); check_fetch("br0", 1'b1, 32'hBFC0_0100);
        set_br(1'b0, 32'h0);
        tick(); check_fetch("br1", 1'b1, 32'hBFC0_0104);

        // Three-cycle stall, redirect in the second stalled cycle
        stall[0] = STOP;
        tick(); check_fetch("st1", 1'b1, 32'hBFC0_0104);
        set_br(1'b1, 32'h8000_0040);
        tick(); check_fetch("st2", 1'b1, 32'hBFC0_0104);
        set_br(1'b0, 32'h0);
        tick(); check_fetch("st3", 1'b1, 32'hBFC0_0104);
        stall[0] = NO_STOP;
        tick(); check_fetch("pend_take", 1'b1, 32'h8000_0040);
        tick(); check_fetch("pend_seq", 1'b1, 32'h8000_0044);

        // Live redirect on release beats pending; pending is then dropped
        stall[0] = STOP;
        tick(); check_fetch("pr_hold0", 1'b1, 32'h8000_0044);
        set_br(1'b1, 32'h8000_0040);
        tick(); check_fetch("pr_hold1", 1'b1, 32'h8000_0044);
        stall[0] = NO_STOP;
        set_br(1'b1, 32'h8000_0080);
        tick(); check_fetch("pr_live", 1'b1, 32'h8000_0080);
        set_br(1'b0, 32'h0);
        tick(); check_fetch("pr_clr", 1'b1, 32'h8000_0084);

        // Repeated redirects during a stall: last one wins, single redirect
        stall[0] = STOP;
        set_br(1'b1, 32'h0000_0010);
        tick(); check_fetch("rep0", 1'b1, 32'h8000_0084);
        set_br(1'b1, 32'h0000_0020);
        tick(); check_fetch("rep1", 1'b1, 32'h8000_0084);
        set_br(1'b1, 32'h0000_0030);
        tick(); check_fetch("rep2", 1'b1, 32'h8000_0084);
        set_br(1'b0, 32'h0);
        stall[0] = NO_STOP;
        tick(); check_fetch("rep_take", 1'b1, 32'h0000_0030);
        tick(); check_fetch("rep_seq", 1'b1, 32'h0000_0034);

        // PC wrap at the top of the address space
        set_br(1'b1, 32'hFFFF_FFFC);
        tick(); check_fetch("wrap0", 1'b1, 32'hFFFF_FFFC);
        set_br(1'b0, 32'h0);
        tick(); check_fetch("wrap1", 1'b1, 32'h0000_0000);
        tick(); check_fetch("wrap2", 1'b1, 32'h0000_0004);

        // Unaligned redirect taken as-is
        set_br(1'b1, 32'h0000_0103);
        tick(); check_fetch("unal0", 1'b1, 32'h0000_0103);
        set_br(1'b0, 32'h0);
        tick(); check_fetch("unal1", 1'b1, 32'h0000_0107);

        // Asynchronous reset mid-hold discards the pending redirect
        stall[0] = STOP;
        tick(); check_fetch("ar_hold", 1'b1, 32'h0000_0107);
        set_br(1'b1, 32'h1234_5678);
        tick(); check_fetch("ar_pend", 1'b1, 32'h0000_0107);
        set_br(1'b0, 32'h0);
        #2;
        rst = 1'b0;
        #1;
        check_fetch("ar_async", 1'b0, 32'hBFBF_FFFC);
        stall[0] = NO_STOP;
        tick(); check_fetch("ar_held", 1'b0, 32'hBFBF_FFFC);
        rst = 1'b1;
        #2;
        check_fetch("ar_idle", 1'b0, 32'hBFBF_FFFC);
        tick(); check_fetch("ar_first", 1'b1, 32'hBFC0_0000);
        tick(); check_fetch("ar_second", 1'b1, 32'hBFC0_0004);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
